// File: rtl/cr_xp10_decomp_htf_pkg.sv
// Shared types and default sizes for the HTF BCT/SAT table reader.
package cr_xp10_decomp_htf_pkg;

  localparam int unsigned HTF_MAX_DEPTH = 27;
  localparam int unsigned HTF_WIDTH     = 10;

  typedef enum logic [1:0] {
    EMPTY,
    LOAD,
    READY,
    SEARCH
  } htf_state_e;

  // Table entries are sized by the package defaults.
  typedef struct packed {
    logic [HTF_MAX_DEPTH-2:0] bct;
    logic [HTF_WIDTH-1:0]     sat;
    logic                     vld;
  } htf_entry_t;

endpackage

// File: rtl/cr_xp10_decomp_htf_bct_sat_reader_if.sv
// Table-write, lookup-request and result bus of the BCT/SAT reader.
interface cr_xp10_decomp_htf_bct_sat_reader_if
  import cr_xp10_decomp_htf_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = HTF_MAX_DEPTH,
  parameter int unsigned WIDTH     = HTF_WIDTH
);
  localparam int unsigned AW = $clog2(MAX_DEPTH + 1);

  logic                 bct_sat_wen;
  logic [AW-1:0]        bct_sat_addr;
  logic                 bct_sat_last;
  logic                 bct_valid;
  logic [MAX_DEPTH-2:0] bct_data;
  logic [WIDTH-1:0]     sat_data;
  logic                 bct_sat_error;
  logic                 lkp_valid;
  logic [MAX_DEPTH-1:0] lkp_window;
  logic                 lkp_ready;
  logic                 sym_valid;
  logic [WIDTH-1:0]     sym_addr;
  logic [AW-1:0]        sym_len;
  logic                 sym_error;
  logic                 tbl_ready;
  logic                 tbl_error;

  modport master (
    output bct_sat_wen, bct_sat_addr, bct_sat_last, bct_valid, bct_data, sat_data,
           bct_sat_error, lkp_valid, lkp_window,
    input  lkp_ready, sym_valid, sym_addr, sym_len, sym_error, tbl_ready, tbl_error
  );

  modport slave (
    input  bct_sat_wen, bct_sat_addr, bct_sat_last, bct_valid, bct_data, sat_data,
           bct_sat_error, lkp_valid, lkp_window,
    output lkp_ready, sym_valid, sym_addr, sym_len, sym_error, tbl_ready, tbl_error
  );

endinterface

// File: rtl/cr_xp10_decomp_htf_bct_sat_match.sv
// Single-length canonical-Huffman compare and symbol-address compute.
module cr_xp10_decomp_htf_bct_sat_match
  import cr_xp10_decomp_htf_pkg::*;
#(
  parameter  int unsigned MAX_DEPTH = HTF_MAX_DEPTH,
  parameter  int unsigned WIDTH     = HTF_WIDTH,
  localparam int unsigned AW        = $clog2(MAX_DEPTH + 1)
) (
  input  logic [MAX_DEPTH-1:0] window,
  input  logic [AW-1:0]        len,
  input  logic [AW-1:0]        last_len,
  input  htf_entry_t           ent,
  input  logic [MAX_DEPTH-2:0] bct_next,
  output logic                 hit,
  output logic [WIDTH-1:0]     addr
);

  logic [MAX_DEPTH-1:0] code;
  logic [MAX_DEPTH-1:0] first;

  always_comb begin
    code  = window >> (MAX_DEPTH - 32'(len));
    first = {ent.bct, 1'b0};
    addr  = WIDTH'(MAX_DEPTH'(ent.sat) + code - first);
    // Below the longest length, codes of length len end where length len+1 starts
    if (len == last_len) hit = ent.vld;
    else                 hit = ent.vld && (code < MAX_DEPTH'(bct_next));
  end

endmodule

// File: rtl/cr_xp10_decomp_htf_bct_sat_reader.sv
// Captures the BCT/SAT table and serves lookups one code length per cycle.
module cr_xp10_decomp_htf_bct_sat_reader
  import cr_xp10_decomp_htf_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = HTF_MAX_DEPTH,
  parameter int unsigned WIDTH     = HTF_WIDTH
) (
  input logic clk,
  input logic rst,
  cr_xp10_decomp_htf_bct_sat_reader_if.slave bus
);

  localparam int unsigned AW    = $clog2(MAX_DEPTH + 1);
  localparam int unsigned SLOTS = 2 ** AW;

  htf_state_e           state;
  htf_entry_t           tbl [SLOTS];
  logic [AW-1:0]        last_len;
  logic [AW-1:0]        cur_len;
  logic [MAX_DEPTH-1:0] win;
  logic                 wr_ok;
  logic                 hit;
  logic [WIDTH-1:0]     hit_addr;

  assign wr_ok = bus.bct_sat_wen && (bus.bct_sat_addr != '0) &&
                 (32'(bus.bct_sat_addr) <= MAX_DEPTH);

  cr_xp10_decomp_htf_bct_sat_match #(
    .MAX_DEPTH (MAX_DEPTH),
    .WIDTH     (WIDTH)
  ) u_match (
    .window   (win),
    .len      (cur_len),
    .last_len (last_len),
    .ent      (tbl[cur_len]),
    .bct_next (tbl[cur_len + 1'b1].bct),
    .hit      (hit),
    .addr     (hit_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      for (int unsigned i = 0; i < SLOTS; i++) tbl[i].vld <= 1'b0;
      last_len <= '0;
      cur_len  <= '0;
      win      <= '0;
      bus.lkp_ready <= 1'b0;
      bus.sym_valid <= 1'b0;
      bus.sym_addr  <= '0;
      bus.sym_len   <= '0;
      bus.sym_error <= 1'b0;
      bus.tbl_ready <= 1'b0;
      bus.tbl_error <= 1'b0;
    end else begin
      bus.sym_valid <= 1'b0;
      bus.sym_error <= 1'b0;
      // Any table change under a running search ends it with an error result
      if ((bus.bct_sat_error || wr_ok) && state == SEARCH) begin
        bus.sym_valid <= 1'b1;
        bus.sym_error <= 1'b1;
        bus.sym_addr  <= '0;
        bus.sym_len   <= cur_len;
      end
      if (bus.bct_sat_error) begin
        for (int unsigned i = 0; i < SLOTS; i++) tbl[i].vld <= 1'b0;
        state         <= EMPTY;
        bus.tbl_error <= 1'b1;
        bus.tbl_ready <= 1'b0;
        bus.lkp_ready <= 1'b0;
      end else if (wr_ok) begin
        if (bus.bct_sat_addr == AW'(1)) begin
          for (int unsigned i = 0; i < SLOTS; i++) tbl[i].vld <= 1'b0;
          bus.tbl_error <= 1'b0;
        end
        tbl[bus.bct_sat_addr].bct <= bus.bct_data;
        tbl[bus.bct_sat_addr].sat <= bus.sat_data;
        tbl[bus.bct_sat_addr].vld <= bus.bct_valid;
        if (bus.bct_sat_last) begin
          last_len      <= bus.bct_sat_addr;
          state         <= READY;
          bus.tbl_ready <= 1'b1;
        end else begin
          state         <= LOAD;
          bus.tbl_ready <= 1'b0;
        end
        bus.lkp_ready <= bus.bct_sat_last && (state != SEARCH);
      end else begin
        case (state)
          READY: begin
            if (bus.lkp_valid && bus.lkp_ready) begin
              win           <= bus.lkp_window;
              cur_len       <= AW'(1);
              state         <= SEARCH;
              bus.lkp_ready <= 1'b0;
            end else begin
              bus.lkp_ready <= 1'b1;
            end
          end
          SEARCH: begin
            if (hit || cur_len == last_len) begin
              bus.sym_valid <= 1'b1;
              bus.sym_error <= !hit;
              bus.sym_addr  <= hit ? hit_addr : '0;
              bus.sym_len   <= cur_len;
              state         <= READY;
            end else begin
              cur_len <= cur_len + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/cr_xp10_decomp_htf_bct_sat_reader.md
Name: cr_xp10_decomp_htf_bct_sat_reader

Overview:
- Receiving end of the HTF BCT/SAT write interface.
- Captures the per-code-length BCT and SAT entries streamed by the table builder into a local register table.
- Serves canonical-Huffman lookups: given a left-justified bit window, it searches code lengths 1..last, one length per cycle, and returns the code length and symbol address (SAT base plus offset).
- Sits between the HTF table builder and the symbol-decode stage of the XP10 decompressor.

Parameters:
- MAX_DEPTH, 27, maximum code length in bits; the table has entries 1..MAX_DEPTH.
- WIDTH, 10, symbol-address and SAT width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- bct_sat_wen  in  1  table write strobe.
- bct_sat_addr  in  $clog2(MAX_DEPTH+1)  code length L of the entry being written (1..MAX_DEPTH).
- bct_sat_last  in  1  qualifies the final entry; bct_sat_addr is the longest length in use.
- bct_valid  in  1  length L has at least one code.
- bct_data  in  MAX_DEPTH-1  first canonical code of length L, shifted right by 1.
- sat_data  in  WIDTH  number of symbols with length < L.
- bct_sat_error  in  1  builder detected an oversubscribed histogram.
- lkp_valid  in  1  lookup request.
- lkp_window  in  MAX_DEPTH  next input bits, MSB = first bit of the code.
- lkp_ready  out  1  lookup can be accepted.
- sym_valid  out  1  single-cycle result pulse; no backpressure.
- sym_addr  out  WIDTH  symbol address.
- sym_len  out  $clog2(MAX_DEPTH+1)  matched code length.
- sym_error  out  1  qualifies sym_valid; the lookup failed.
- tbl_ready  out  1  a complete table is loaded.
- tbl_error  out  1  sticky; the last load was aborted by bct_sat_error.

Behaviour:
- Storage per L: bct[L] (MAX_DEPTH-1 bits), sat[L] (WIDTH bits), vld[L] (1 bit), plus last_len.
- first_code[L] = {bct[L], 1'b0}, zero-extended to MAX_DEPTH bits.
- code_L = lkp_window[MAX_DEPTH-1 -: L], zero-extended.
- Match at L:
  - L < last_len: vld[L] && code_L < bct[L+1].
  - L == last_len: match iff vld[L].
- Result on match: sym_addr = WIDTH'(sat[L] + code_L - first_code[L]); sym_len = L.
- No match at last_len -> sym_error=1, sym_addr=0, sym_len=last_len.
- FSM states:
  - EMPTY: tbl_ready=0.
  - LOAD: receiving entries.
  - READY: lkp_ready=1.
  - SEARCH: cur_len counter running.
- Transitions:
  - Any state, wen && addr==1: clear all vld, clear tbl_error, go to LOAD. Writes take priority over lookups.
  - LOAD, each wen: write bct/sat/vld at addr.
  - LOAD, wen && last: last_len=addr, go to READY.
  - Any state, bct_sat_error: go to EMPTY, tbl_error=1, vld cleared.
  - READY, lkp_valid: capture window, cur_len=1, go to SEARCH.
  - SEARCH, each cycle: evaluate cur_len.
    - On match or cur_len==last_len: return to READY.
    - Otherwise: cur_len+1.
- Latency: lookup accepted in cycle T and matched at length L -> sym_valid in cycle T+1+L. Outputs are registered.
- lkp_ready=0 in the cycle sym_valid is driven; the next lookup is accepted no earlier than the following cycle.
- Boundaries:
  - A write arriving during SEARCH aborts the search: sym_valid=1, sym_error=1 in the next cycle.
  - lkp_valid in EMPTY/LOAD is ignored (lkp_ready=0).
  - wen with addr==0 or addr>MAX_DEPTH is dropped.
  - A write to a non-sequential address is still stored; ordering is not checked.
  - last_len==1 is legal.
- Reset values:
  - Outputs: lkp_ready=0, sym_valid=0, sym_addr=0, sym_len=0, sym_error=0, tbl_ready=0, tbl_error=0.
  - Internal: state=EMPTY, vld all 0.
  - Reset mid-search discards the search without producing a result.

Decomposition:
- Shared package cr_xp10_decomp_htf_pkg holds:
  - FSM enum {EMPTY, LOAD, READY, SEARCH}.
  - Entry struct {bct, sat, vld}.
  - Default MAX_DEPTH/WIDTH constants.
- Sub-module cr_xp10_decomp_htf_bct_sat_match: combinational single-length compare and address compute. It is instantiated once and indexed by cur_len.

Test Plan:
- Load: counts {L1:1, L2:1, L3:2}; entries (addr, bct, sat, vld) = (1,0,0,1), (2,1,1,1), (3,3,2,1), last at 3. Expect tbl_ready=1 one cycle after the last write.
- Lookup window 0xxx.. (MSB=0) accepted at cycle 0 -> sym_valid at cycle 2, sym_addr=0, sym_len=1.
- Window 10.. -> sym_addr=1, sym_len=2, pulse at cycle 3.
- Windows 110.. and 111.. -> sym_addr=2 and 3, sym_len=3, pulse at cycle 4.
- bct_sat_error during LOAD -> tbl_ready=0, tbl_error=1, lkp_ready=0. A subsequent full reload clears tbl_error.
- Write addr=1 issued while a lookup is in SEARCH at length 2 -> next cycle sym_valid=1, sym_error=1; state LOAD.
- Assert rst mid-SEARCH -> no sym_valid; all outputs 0 next cycle; state EMPTY.
